// File: rtl/alu_seq_unit.sv
// alu_seq_unit: decoded ALU with an iterative shift-add unsigned multiplier.
//
// A request (ALUOp/FuncCode/A/B) is taken when InValid & InReady. Operands and
// the decoded control are registered on accept. Single-cycle ops spend one
// execute cycle and present their result on the next edge. multu runs WIDTH
// shift-add iterations, one multiplier bit per cycle. The result is held with
// OutValid=1 until OutReady. A new request may be accepted on the same edge
// that the held result retires.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   InValid / InReady    request handshake
//   ALUOp, FuncCode      operation select (R-type uses FuncCode)
//   A, B                 operands (shift amount = low log2(WIDTH) bits of B)
//   OutValid / OutReady  result handshake
//   Result, ResultHi     result / low product word, high product word
//   Zero                 Result == 0
//   ALUCtl, Illegal      decoded control of the held result, undefined-op flag
module alu_seq_unit #(
  parameter int WIDTH  = 32,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       FuncCode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] ResultHi,
  output logic             Zero,
  output logic [3:0]       ALUCtl,
  output logic             Illegal
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [3:0] CTL_AND   = 4'b0000;
  localparam logic [3:0] CTL_OR    = 4'b0001;
  localparam logic [3:0] CTL_ADD   = 4'b0010;
  localparam logic [3:0] CTL_XOR   = 4'b0011;
  localparam logic [3:0] CTL_SUB   = 4'b0110;
  localparam logic [3:0] CTL_SLT   = 4'b0111;
  localparam logic [3:0] CTL_SLTU  = 4'b1000;
  localparam logic [3:0] CTL_SLL   = 4'b1001;
  localparam logic [3:0] CTL_SRL   = 4'b1010;
  localparam logic [3:0] CTL_SRA   = 4'b1011;
  localparam logic [3:0] CTL_NOR   = 4'b1100;
  localparam logic [3:0] CTL_MULTU = 4'b1101;
  localparam logic [3:0] CTL_ILL   = 4'b1111;

  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

  function automatic logic [3:0] decode(input logic [1:0] op, input logic [5:0] funct);
    logic [3:0] ctl;
    ctl = CTL_ILL;
    case (op)
      2'b00: ctl = CTL_ADD;
      2'b01: ctl = CTL_SUB;
      2'b10: begin
        case (funct)
          6'b100000: ctl = CTL_ADD;
          6'b100010: ctl = CTL_SUB;
          6'b100100: ctl = CTL_AND;
          6'b100101: ctl = CTL_OR;
          6'b100110: ctl = CTL_XOR;
          6'b100111: ctl = CTL_NOR;
          6'b101010: ctl = CTL_SLT;
          6'b101011: ctl = CTL_SLTU;
          6'b000000: ctl = CTL_SLL;
          6'b000010: ctl = CTL_SRL;
          6'b000011: ctl = CTL_SRA;
          6'b011001: ctl = (MUL_EN != 0) ? CTL_MULTU : CTL_ILL;
          default:   ctl = CTL_ILL;
        endcase
      end
      default: ctl = CTL_ILL;
    endcase
    return ctl;
  endfunction

  // Illegal and multu both yield 0 here; multu results come from the iterator.
  function automatic logic [WIDTH-1:0] alu_exec(input logic [3:0] ctl,
                                                input logic signed [WIDTH-1:0] a,
                                                input logic signed [WIDTH-1:0] b);
    logic [CNT_W-1:0] sh;
    logic [WIDTH-1:0] r;
    sh = b[CNT_W-1:0];
    r  = '0;
    case (ctl)
      CTL_ADD:  r = a + b;
      CTL_SUB:  r = a - b;
      CTL_AND:  r = a & b;
      CTL_OR:   r = a | b;
      CTL_XOR:  r = a ^ b;
      CTL_NOR:  r = ~(a | b);
      CTL_SLT:  r = {{(WIDTH-1){1'b0}}, (a < b)};
      CTL_SLTU: r = {{(WIDTH-1){1'b0}}, ($unsigned(a) < $unsigned(b))};
      CTL_SLL:  r = a << sh;
      CTL_SRL:  r = $unsigned(a) >> sh;
      CTL_SRA:  r = a >>> sh;
      default:  r = '0;
    endcase
    return r;
  endfunction

  state_t                   state;
  logic [CNT_W-1:0]         cnt;
  logic [3:0]               dec_ctl;
  logic                     accept;

  logic signed [WIDTH-1:0]  a_p0;
  logic signed [WIDTH-1:0]  b_p0;
  logic [3:0]               ctl_p0;
  logic [WIDTH-1:0]         mhi_p0;
  logic [WIDTH-1:0]         mlo_p0;

  logic [WIDTH:0]           mul_sum;
  logic [WIDTH-1:0]         mul_hi_nxt;
  logic [WIDTH-1:0]         mul_lo_nxt;

  logic                     vld_p1;
  logic [WIDTH-1:0]         res_p1;
  logic [WIDTH-1:0]         reshi_p1;
  logic                     zero_p1;
  logic [3:0]               ctl_p1;
  logic                     ill_p1;

  assign dec_ctl = decode(ALUOp, FuncCode);
  assign InReady = (state == IDLE) || ((state == DONE) && OutReady);
  assign accept  = InValid && InReady;

  // Shift-add step: {hi,lo} starts as {0,B}; each step conditionally adds A to
  // hi and shifts the pair right, so after WIDTH steps {hi,lo} = A*B.
  assign mul_sum    = {1'b0, mhi_p0} + (mlo_p0[0] ? {1'b0, $unsigned(a_p0)} : {(WIDTH+1){1'b0}});
  assign mul_hi_nxt = mul_sum[WIDTH:1];
  assign mul_lo_nxt = {mul_sum[0], mlo_p0[WIDTH-1:1]};

  // ---- stage p0: operand capture and multiplier iteration (data only) ----
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p0   <= A;
      b_p0   <= B;
      ctl_p0 <= dec_ctl;
      mhi_p0 <= '0;
      mlo_p0 <= B;
    end else if (state == MUL) begin
      mhi_p0 <= mul_hi_nxt;
      mlo_p0 <= mul_lo_nxt;
    end
  end

  // ---- stage p1: sequencing and held result ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      vld_p1   <= 1'b0;
      res_p1   <= '0;
      reshi_p1 <= '0;
      zero_p1  <= 1'b1;
      ctl_p1   <= 4'b0000;
      ill_p1   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            state  <= (dec_ctl == CTL_MULTU) ? MUL : EXEC;
            cnt    <= '0;
            vld_p1 <= 1'b0;
          end else if ((state == DONE) && OutReady) begin
            state  <= IDLE;
            vld_p1 <= 1'b0;
          end
        end
        EXEC: begin
          res_p1   <= alu_exec(ctl_p0, a_p0, b_p0);
          reshi_p1 <= '0;
          zero_p1  <= (alu_exec(ctl_p0, a_p0, b_p0) == '0);
          ctl_p1   <= ctl_p0;
          ill_p1   <= (ctl_p0 == CTL_ILL);
          vld_p1   <= 1'b1;
          state    <= DONE;
        end
        MUL: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            res_p1   <= mul_lo_nxt;
            reshi_p1 <= mul_hi_nxt;
            zero_p1  <= (mul_lo_nxt == '0);
            ctl_p1   <= ctl_p0;
            ill_p1   <= 1'b0;
            vld_p1   <= 1'b1;
            cnt      <= '0;
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign OutValid = vld_p1;
  assign Result   = res_p1;
  assign ResultHi = reshi_p1;
  assign Zero     = zero_p1;
  assign ALUCtl   = ctl_p1;
  assign Illegal  = ill_p1;

endmodule

// File: tb/tb_alu_seq_unit.sv
module tb_alu_seq_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        InValid;
  logic        InReady;
  logic [1:0]  ALUOp;
  logic [5:0]  FuncCode;
  logic [31:0] A;
  logic [31:0] B;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] Result;
  logic [31:0] ResultHi;
  logic        Zero;
  logic [3:0]  ALUCtl;
  logic        Illegal;

  int checks   = 0;
  int failures = 0;

  alu_seq_unit #(.WIDTH(32), .MUL_EN(1)) dut (
    .clk(clk), .reset(reset),
    .InValid(InValid), .InReady(InReady),
    .ALUOp(ALUOp), .FuncCode(FuncCode), .A(A), .B(B),
    .OutValid(OutValid), .OutReady(OutReady),
    .Result(Result), .ResultHi(ResultHi), .Zero(Zero),
    .ALUCtl(ALUCtl), .Illegal(Illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour straight from the operation table.
  function automatic void model(input logic [1:0] op, input logic [5:0] f,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [3:0] ctl, output logic ill,
                                output logic [31:0] lo, output logic [31:0] hi,
                                output int lat);
    logic [63:0] p;
    ctl = 4'hF; ill = 1'b1; lo = '0; hi = '0; lat = 1;
    if (op == 2'b00) begin
      ctl = 4'b0010; ill = 1'b0; lo = a + b;
    end else if (op == 2'b01) begin
      ctl = 4'b0110; ill = 1'b0; lo = a - b;
    end else if (op == 2'b10) begin
      ill = 1'b0;
      case (f)
        6'h20: begin ctl = 4'b0010; lo = a + b; end
        6'h22: begin ctl = 4'b0110; lo = a - b; end
        6'h24: begin ctl = 4'b0000; lo = a & b; end
        6'h25: begin ctl = 4'b0001; lo = a | b; end
        6'h26: begin ctl = 4'b0011; lo = a ^ b; end
        6'h27: begin ctl = 4'b1100; lo = ~(a | b); end
        6'h2A: begin ctl = 4'b0111; lo = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
        6'h2B: begin ctl = 4'b1000; lo = (a < b) ? 32'd1 : 32'd0; end
        6'h00: begin ctl = 4'b1001; lo = a << b[4:0]; end
        6'h02: begin ctl = 4'b1010; lo = a >> b[4:0]; end
        6'h03: begin ctl = 4'b1011; lo = $unsigned($signed(a) >>> b[4:0]); end
        6'h19: begin
          ctl = 4'b1101; p = {32'd0, a} * {32'd0, b};
          lo = p[31:0]; hi = p[63:32]; lat = 32;
        end
        default: begin ctl = 4'hF; ill = 1'b1; end
      endcase
    end
  endfunction

  // Issues one request (retiring any held result on the same edge), waits for
  // its result and leaves it held with OutReady=0.
  task automatic do_op(input logic [1:0] op, input logic [5:0] f,
                       input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [3:0]  ectl;
    logic        eill;
    logic [31:0] elo, ehi;
    int          elat, lat;
    logic        busy_ok;
    model(op, f, a, b, ectl, eill, elo, ehi, elat);
    ALUOp = op; FuncCode = f; A = a; B = b; InValid = 1'b1; OutReady = 1'b1;
    #1;
    chk({tag, "_inready"}, InReady, 1);
    @(posedge clk); #1;
    InValid = 1'b0; OutReady = 1'b0; A = $urandom; B = $urandom;
    ALUOp = 2'($urandom); FuncCode = 6'($urandom);
    lat = 0; busy_ok = 1'b1;
    while (OutValid !== 1'b1 && lat < 64) begin
      if (InReady !== 1'b0) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, elat);
    chk({tag, "_busy_inready0"}, busy_ok, 1);
    chk({tag, "_result"}, Result, elo);
    chk({tag, "_resulthi"}, ResultHi, ehi);
    chk({tag, "_zero"}, Zero, (elo == 32'd0));
    chk({tag, "_aluctl"}, ALUCtl, ectl);
    chk({tag, "_illegal"}, Illegal, eill);
  endtask

  task automatic retire(input string tag);
    OutReady = 1'b1; InValid = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_outvalid0"}, OutValid, 0);
    chk({tag, "_inready1"}, InReady, 1);
    OutReady = 1'b0;
  endtask

  logic [5:0]  ftab [13];
  logic [31:0] held_lo, held_hi;
  logic [31:0] ra, rb;
  logic [5:0]  rf;

  initial begin
    ftab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
             6'h00, 6'h02, 6'h03, 6'h19, 6'h3F};
    reset = 1'b1; InValid = 1'b0; OutReady = 1'b0;
    ALUOp = 2'b00; FuncCode = 6'h00; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_outvalid", OutValid, 0);
    chk("rst_inready", InReady, 1);
    chk("rst_result", Result, 0);
    chk("rst_resulthi", ResultHi, 0);
    chk("rst_zero", Zero, 1);
    chk("rst_aluctl", ALUCtl, 4'b0000);
    chk("rst_illegal", Illegal, 0);

    do_op(2'b00, 6'h00, 32'd5, 32'd7, "add5_7");
    chk("add5_7_lit", Result, 32'd12);
    do_op(2'b01, 6'h00, 32'h1234, 32'h1234, "beq_sub");
    chk("beq_sub_lit_zero", Zero, 1);
    do_op(2'b10, 6'h2A, 32'hFFFF_FFFF, 32'd1, "slt");
    chk("slt_lit", Result, 32'd1);
    do_op(2'b10, 6'h2B, 32'hFFFF_FFFF, 32'd1, "sltu");
    chk("sltu_lit", Result, 32'd0);
    do_op(2'b10, 6'h00, 32'h8000_0001, 32'd4, "sll");
    chk("sll_lit", Result, 32'h0000_0010);
    do_op(2'b10, 6'h02, 32'h8000_0001, 32'd4, "srl");
    chk("srl_lit", Result, 32'h0800_0000);
    do_op(2'b10, 6'h03, 32'h8000_0001, 32'd4, "sra");
    chk("sra_lit", Result, 32'hF800_0000);
    do_op(2'b10, 6'h27, 32'd0, 32'd0, "nor");
    chk("nor_lit", Result, 32'hFFFF_FFFF);
    retire("retire_idle");

    do_op(2'b10, 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    chk("multu_lit_hi", ResultHi, 32'hFFFF_FFFE);
    chk("multu_lit_lo", Result, 32'h0000_0001);
    chk("multu_lit_ctl", ALUCtl, 4'b1101);

    // Hold the result under backpressure.
    held_lo = Result; held_hi = ResultHi;
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("bp_result_stable", Result, held_lo);
    chk("bp_resulthi_stable", ResultHi, held_hi);
    chk("bp_outvalid_held", OutValid, 1);
    chk("bp_inready0", InReady, 0);
    do_op(2'b00, 6'h00, 32'd1, 32'd1, "b2b_add");
    chk("b2b_add_lit", Result, 32'd2);

    do_op(2'b11, 6'h20, 32'd9, 32'd9, "illegal_op11");
    chk("illegal_op11_lit", ALUCtl, 4'hF);
    do_op(2'b10, 6'h3F, 32'd9, 32'd9, "illegal_f3f");
    chk("illegal_f3f_lit", Result, 32'd0);

    // Reset during a multiply.
    ALUOp = 2'b10; FuncCode = 6'h19; A = 32'h1234_5678; B = 32'h9ABC_DEF0;
    InValid = 1'b1; OutReady = 1'b1;
    @(posedge clk); #1;
    InValid = 1'b0; OutReady = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk("mulrst_busy", InReady, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mulrst_outvalid", OutValid, 0);
    chk("mulrst_inready", InReady, 1);
    chk("mulrst_result", Result, 0);
    chk("mulrst_resulthi", ResultHi, 0);
    chk("mulrst_zero", Zero, 1);
    chk("mulrst_aluctl", ALUCtl, 0);
    do_op(2'b00, 6'h00, 32'd100, 32'd23, "post_rst_add");
    retire("post_rst_retire");
    repeat (30) begin
      @(posedge clk); #1;
    end
    chk("post_rst_no_ghost", OutValid, 0);

    // Randomised operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: ra = 32'd0;
        1: ra = 32'hFFFF_FFFF;
        2: ra = 32'h8000_0000;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'd1;
        default: rb = $urandom;
      endcase
      rf = ftab[$urandom_range(0, 12)];
      if ($urandom_range(0, 3) == 0) rf = 6'($urandom);
      do_op(2'($urandom_range(0, 3)), rf, ra, rb, $sformatf("rnd%0d", i));
      if ($urandom_range(0, 2) == 0) retire($sformatf("rnd%0d_retire", i));
    end
    retire("final_retire");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
